// File: rtl/vx_retire_counters.sv
// vx_retire_counters: machine-mode mcycle/minstret/mcountinhibit counters with a registered CSR read port
module vx_retire_counters #(
    parameter int CORE_ID    = 0,
    parameter int CMT_SIZE_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmt_valid,
    input  logic [CMT_SIZE_W-1:0] cmt_commit_size,
    input  logic                  csr_read_valid,
    input  logic [11:0]           csr_read_addr,
    output logic                  csr_read_rsp_valid,
    output logic [31:0]           csr_read_data,
    output logic                  csr_read_hit,
    input  logic                  csr_write_valid,
    input  logic [11:0]           csr_write_addr,
    input  logic [31:0]           csr_write_data
);
    logic [63:0] mcycle, minstret, cyc_inc, ret_inc, cyc_nxt, ret_nxt;
    logic        inh_cy, inh_ir;
    logic        wr_cyc_lo, wr_cyc_hi, wr_ret_lo, wr_ret_hi, wr_inh;
    logic [31:0] rd_data;
    logic        rd_hit;

    assign wr_cyc_lo = csr_write_valid && csr_write_addr == 12'hB00;
    assign wr_cyc_hi = csr_write_valid && csr_write_addr == 12'hB80;
    assign wr_ret_lo = csr_write_valid && csr_write_addr == 12'hB02;
    assign wr_ret_hi = csr_write_valid && csr_write_addr == 12'hB82;
    assign wr_inh    = csr_write_valid && csr_write_addr == 12'h320;

    assign cyc_inc = mcycle + {63'd0, !inh_cy};
    assign ret_inc = minstret + ((cmt_valid && !inh_ir) ? {{(64-CMT_SIZE_W){1'b0}}, cmt_commit_size} : 64'd0);

    // a write replaces one half and suppresses that cycle's increment
    assign cyc_nxt = wr_cyc_lo ? {mcycle[63:32], csr_write_data} :
                     wr_cyc_hi ? {csr_write_data, mcycle[31:0]} : cyc_inc;
    assign ret_nxt = wr_ret_lo ? {minstret[63:32], csr_write_data} :
                     wr_ret_hi ? {csr_write_data, minstret[31:0]} : ret_inc;

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (csr_read_addr)
            12'hB00, 12'hC00: rd_data = mcycle[31:0];
            12'hB80, 12'hC80: rd_data = mcycle[63:32];
            12'hB02, 12'hC02: rd_data = minstret[31:0];
            12'hB82, 12'hC82: rd_data = minstret[63:32];
            12'h320:          rd_data = {29'd0, inh_ir, 1'b0, inh_cy};
            default:          rd_hit  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle             <= '0;
            minstret           <= '0;
            inh_cy             <= 1'b0;
            inh_ir             <= 1'b0;
            csr_read_rsp_valid <= 1'b0;
            csr_read_data      <= '0;
            csr_read_hit       <= 1'b0;
        end else begin
            mcycle             <= cyc_nxt;
            minstret           <= ret_nxt;
            inh_cy             <= wr_inh ? csr_write_data[0] : inh_cy;
            inh_ir             <= wr_inh ? csr_write_data[2] : inh_ir;
            csr_read_rsp_valid <= csr_read_valid;
            csr_read_data      <= csr_read_valid ? rd_data : csr_read_data;
            csr_read_hit       <= csr_read_valid ? rd_hit : csr_read_hit;
        end
    end
endmodule

// File: tb/tb_vx_retire_counters.sv
// tb_vx_retire_counters: directed stimulus with a response scoreboard for vx_retire_counters
module tb_vx_retire_counters;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmt_valid;
    logic [4:0]  cmt_commit_size;
    logic        csr_read_valid;
    logic [11:0] csr_read_addr;
    logic        csr_read_rsp_valid;
    logic [31:0] csr_read_data;
    logic        csr_read_hit;
    logic        csr_write_valid;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_write_data;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   c0 = 0;
    int   checks = 0;
    int   errors = 0;

    vx_retire_counters #(.CORE_ID(0), .CMT_SIZE_W(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmt_valid          (cmt_valid),
        .cmt_commit_size    (cmt_commit_size),
        .csr_read_valid     (csr_read_valid),
        .csr_read_addr      (csr_read_addr),
        .csr_read_rsp_valid (csr_read_rsp_valid),
        .csr_read_data      (csr_read_data),
        .csr_read_hit       (csr_read_hit),
        .csr_write_valid    (csr_write_valid),
        .csr_write_addr     (csr_write_addr),
        .csr_write_data     (csr_write_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every request expects its response exactly one cycle later
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            checks++;
            if (!csr_read_rsp_valid || csr_read_data !== q[0].data || csr_read_hit !== q[0].hit) begin
                errors++;
                $display("FAIL read %h: valid=%b data=%h hit=%b, expected valid=1 data=%h hit=%b",
                         q[0].addr, csr_read_rsp_valid, csr_read_data, csr_read_hit, q[0].data, q[0].hit);
            end
            void'(q.pop_front());
        end else if (csr_read_rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp at cycle %0d: valid=1 data=%h, expected valid=0", cyc, csr_read_data);
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic idle_inputs();
        cmt_valid       = 1'b0;
        cmt_commit_size = '0;
        csr_read_valid  = 1'b0;
        csr_read_addr   = '0;
        csr_write_valid = 1'b0;
        csr_write_addr  = '0;
        csr_write_data  = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h);
        q.push_back('{cyc + 1, a, d, h});
        csr_read_valid = 1'b1;
        csr_read_addr  = a;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_write_valid = 1'b1;
        csr_write_addr  = a;
        csr_write_data  = d;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic cmt(input logic [4:0] s, input int n);
        cmt_valid       = 1'b1;
        cmt_commit_size = s;
        repeat (n) @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, csr_read_rsp_valid}, 32'd0);
        chk("rst_data", csr_read_data, 32'd0);
        chk("rst_hit", {31'd0, csr_read_hit}, 32'd0);
        reset = 1'b0;
        c0 = cyc;
        repeat (10) @(negedge clk);
        rd(12'hB00, 32'd10, 1'b1);
        rd(12'hB82, 32'd0, 1'b1);
        rd(12'hC00, 32'(cyc - c0), 1'b1);
        rd(12'hC80, 32'd0, 1'b1);
        // same-cycle write and read of mcycle
        q.push_back('{cyc + 1, 12'hB00, 32'(cyc - c0), 1'b1});
        csr_read_valid  = 1'b1;
        csr_read_addr   = 12'hB00;
        csr_write_valid = 1'b1;
        csr_write_addr  = 12'hB00;
        csr_write_data  = 32'h100;
        @(negedge clk);
        idle_inputs();
        rd(12'hB00, 32'h100, 1'b1);
        rd(12'hB00, 32'h101, 1'b1);
        rd(12'hB80, 32'd0, 1'b1);
        cmt(5'd4, 5);
        cmt(5'd0, 1);
        rd(12'hB02, 32'd20, 1'b1);
        wr(12'h320, 32'h4);
        rd(12'h320, 32'h4, 1'b1);
        cmt(5'd4, 5);
        rd(12'hB02, 32'd20, 1'b1);
        rd(12'hC02, 32'd20, 1'b1);
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, 32'h5, 1'b1);
        wr(12'h320, 32'h0);
        rd(12'h320, 32'h0, 1'b1);
        wr(12'hB02, 32'hFFFF_FFFE);
        wr(12'hB82, 32'hFFFF_FFFF);
        rd(12'hB82, 32'hFFFF_FFFF, 1'b1);
        cmt(5'd3, 1);
        rd(12'hB02, 32'd1, 1'b1);
        rd(12'hB82, 32'd0, 1'b1);
        wr(12'hC02, 32'h55);
        wr(12'h123, 32'hFF);
        rd(12'h123, 32'd0, 1'b0);
        rd(12'hC02, 32'd1, 1'b1);
        rd(12'hB02, 32'd1, 1'b1);
        rd(12'hC82, 32'd0, 1'b1);
        wr(12'hB02, 32'hFFFF_FFFF);
        wr(12'hB82, 32'h0);
        cmt(5'd1, 1);
        rd(12'hB82, 32'd1, 1'b1);
        rd(12'hB02, 32'd0, 1'b1);
        // reset mid-count with a read pending in the reset cycle
        reset           = 1'b1;
        cmt_valid       = 1'b1;
        cmt_commit_size = 5'd2;
        csr_read_valid  = 1'b1;
        csr_read_addr   = 12'hB00;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        chk("midrst_rsp_valid", {31'd0, csr_read_rsp_valid}, 32'd0);
        chk("midrst_data", csr_read_data, 32'd0);
        chk("midrst_hit", {31'd0, csr_read_hit}, 32'd0);
        rd(12'hB00, 32'd0, 1'b1);
        rd(12'hB02, 32'd0, 1'b1);
        rd(12'h320, 32'd0, 1'b1);
        rd(12'hB80, 32'd0, 1'b1);
        rd(12'hB01, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_retire_counters.md
# vx_retire_counters

Machine-mode performance counter block at the CSR end of the commit-to-CSR interface. It accumulates the per-cycle retired-thread count (`commit_size`) into a 64-bit `minstret` counter and maintains a free-running 64-bit `mcycle` counter. It serves CSR reads and writes of both counters and of `mcountinhibit` for the CSR unit of one core.

## Interface
- CORE_ID, 0, core index (trace/debug only)
- CMT_SIZE_W, 5, width of commit_size (matches commit-side popcount width)
- clk  in  1  clock; **one clock**
- reset  in  1  **reset is synchronous and active-high**
- cmt_valid  in  1  commit-to-CSR valid; no ready, consumer must accept every cycle
- cmt_commit_size  in  CMT_SIZE_W  threads retired this cycle, meaningful when cmt_valid=1
- csr_read_valid  in  1  read request strobe
- csr_read_addr  in  12  CSR address
- csr_read_rsp_valid  out  1  read response strobe
- csr_read_data  out  32  read data
- csr_read_hit  out  1  address decoded by this block
- csr_write_valid  in  1  write strobe
- csr_write_addr  in  12  CSR address
- csr_write_data  in  32  write data

## Operation
- Decoded addresses:
  - mcycle 0xB00 / mcycleh 0xB80 and cycle 0xC00 / cycleh 0xC80 (read-only aliases).
  - minstret 0xB02 / minstreth 0xB82 and instret 0xC02 / instreth 0xC82 (read-only aliases).
  - mcountinhibit 0x320: bits [0] CY and [2] IR implemented; all other bits read 0.
- mcycle: +1 per cycle when inhibit[0]=0.
- minstret: +zero-extended cmt_commit_size per cycle when cmt_valid=1 and inhibit[2]=0. cmt_valid=1 with size 0 adds nothing.
- Arithmetic: both counters are full 64-bit; wrap from 2^64-1 to 0 is modulo with no flag. Carry from the low word propagates into the high word in the same cycle.
- Writes:
  - A write to the low or high half of an M-mode counter replaces that half with csr_write_data. The other half keeps its current (pre-increment) value.
  - That counter's increment is dropped in the write cycle (write wins).
  - Writes to the 0xCxx aliases and to undecoded addresses are ignored.
  - A write to mcountinhibit takes effect on counting from the next cycle.
- Reads:
  - Return the register value as it stands at the start of the request cycle, i.e. before that cycle's increment or write.
  - Undecoded address: data=0, hit=0.
- Simultaneous read and write to the same address: the read returns the old value.
- No internal state machine beyond the counters; the read path is a one-stage registered pipeline.

## Timing
- Reset values: mcycle=0, minstret=0, mcountinhibit=0, csr_read_rsp_valid=0, csr_read_data=0, csr_read_hit=0.
- Counting starts the first cycle after reset deasserts. mcycle reads 1 at the end of that cycle.
- Reset asserted mid-operation clears all state on the next edge. A read issued in the reset cycle produces no response.
- Commit-to-counter latency: a commit presented in cycle N is visible to a read issued in cycle N+1.
- Read latency: exactly 1 cycle.
  - csr_read_rsp_valid is high in cycle N+1 for each request in N.
  - Back-to-back requests are accepted every cycle; there is no backpressure.
  - csr_read_data and csr_read_hit hold their value when no response is issued.
- Write latency: a write in cycle N is visible to a read issued in cycle N+1.

## Test plan
- Reset, then 10 idle cycles; read 0xB00 → 10 and 0xB82 → 0; rsp_valid high exactly 1 cycle after each request.
- Drive cmt_valid=1, size=4 for 5 cycles, then size=0 for 1 cycle; read 0xB02 → 20. Repeat with inhibit[2]=1 set first; minstret stays at 20.
- Write 0xB02=0xFFFFFFFE and 0xB82=0xFFFFFFFF, then commit size 3 → minstret=0x0000_0000_0000_0001. Reads of 0xB02 → 1 and 0xB82 → 0 (64-bit wrap).
- In the same cycle write 0xB00=0x100 and read 0xB00: read returns the old value. Next-cycle read → 0x100, not 0x101.
- Write 0xC02=0x55 and 0x123=0xFF: no state change. Read 0x123 → data 0, hit 0. Read 0xC02 equals 0xB02.
- Assert reset for 1 cycle mid-count with a pending read: no rsp_valid; all counters and outputs read 0 afterward.
